// File: rtl/ex_alu_stage_if.sv
// rtl/ex_alu_stage_if.sv - operand-in / result-out stream bundle for the EX ALU stage
interface ex_alu_stage_if #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_op;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [4:0]       in_rd;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [4:0]       out_rd;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_op, in_a, in_b, in_rd, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_rd, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_tag, out_illegal
   );
endinterface

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - RV64I execute-stage ALU with EX/MEM result register
module ex_alu_stage #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   ex_alu_stage_if.slave    bus,
   output logic [CNT_W-1:0] ops_count,
   output logic [CNT_W-1:0] stall_count
);
   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_SH1ADD = 5'd10,
      OP_SH2ADD = 5'd11,
      OP_SH3ADD = 5'd12,
      OP_ADDW   = 5'd13,
      OP_SUBW   = 5'd14,
      OP_SLLW   = 5'd15,
      OP_SRLW   = 5'd16,
      OP_SRAW   = 5'd17
   } alu_op_t;

   logic [XLEN-1:0]  a, b;
   logic [5:0]       sh;
   logic [4:0]       sh_w;
   logic [31:0]      a_w, b_w;
   logic [31:0]      addw, subw, sllw, srlw, sraw;
   logic [XLEN-1:0]  alu_result;
   logic             illegal_op;
   logic [TAG_W-1:0] tag_next;
   logic             accept;

   assign a        = bus.in_a;
   assign b        = bus.in_b;
   assign sh       = bus.in_b[5:0];
   assign sh_w     = bus.in_b[4:0];
   assign a_w      = bus.in_a[31:0];
   assign b_w      = bus.in_b[31:0];
   assign tag_next = bus.in_tag;

   assign addw = a_w + b_w;
   assign subw = a_w - b_w;
   assign sllw = a_w << sh_w;
   assign srlw = a_w >> sh_w;
   assign sraw = 32'($signed(a_w) >>> sh_w);

   // Word ops produce a 32-bit value that is then sign-extended from bit 31.
   always_comb begin
      alu_result = '0;
      illegal_op = 1'b0;
      case (bus.in_op)
         OP_ADD:    alu_result = a + b;
         OP_SUB:    alu_result = a - b;
         OP_AND:    alu_result = a & b;
         OP_OR:     alu_result = a | b;
         OP_XOR:    alu_result = a ^ b;
         OP_SLL:    alu_result = a << sh;
         OP_SRL:    alu_result = a >> sh;
         OP_SRA:    alu_result = XLEN'($signed(a) >>> sh);
         OP_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU:   alu_result = {{(XLEN-1){1'b0}}, a < b};
         OP_SH1ADD: alu_result = (a << 1) + b;
         OP_SH2ADD: alu_result = (a << 2) + b;
         OP_SH3ADD: alu_result = (a << 3) + b;
         OP_ADDW:   alu_result = {{(XLEN-32){addw[31]}}, addw};
         OP_SUBW:   alu_result = {{(XLEN-32){subw[31]}}, subw};
         OP_SLLW:   alu_result = {{(XLEN-32){sllw[31]}}, sllw};
         OP_SRLW:   alu_result = {{(XLEN-32){srlw[31]}}, srlw};
         OP_SRAW:   alu_result = {{(XLEN-32){sraw[31]}}, sraw};
         default:   illegal_op = 1'b1;
      endcase
   end

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid   <= 1'b0;
         bus.out_result  <= '0;
         bus.out_rd      <= '0;
         bus.out_tag     <= '0;
         bus.out_illegal <= 1'b0;
         ops_count       <= '0;
         stall_count     <= '0;
      end else begin
         if (accept) begin
            bus.out_result  <= alu_result;
            bus.out_rd      <= bus.in_rd;
            bus.out_tag     <= tag_next;
            bus.out_illegal <= illegal_op;
            ops_count       <= ops_count + 1'b1;
         end
         // A drain with a simultaneous accept keeps out_valid high.
         if (flush)
            bus.out_valid <= 1'b0;
         else if (accept)
            bus.out_valid <= 1'b1;
         else if (bus.out_ready)
            bus.out_valid <= 1'b0;
         if (bus.out_valid && !bus.out_ready && !flush)
            stall_count <= stall_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - self-checking bench for ex_alu_stage
module tb_ex_alu_stage;
   localparam int XLEN  = 64;
   localparam int TAG_W = 8;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [CNT_W-1:0] ops_count;
   logic [CNT_W-1:0] stall_count;

   ex_alu_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   ex_alu_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus),
      .ops_count   (ops_count),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic             m_valid;
   logic [63:0]      m_result;
   logic [4:0]       m_rd;
   logic [TAG_W-1:0] m_tag;
   logic             m_ill;
   logic [CNT_W-1:0] m_ops;
   logic [CNT_W-1:0] m_stall;

   typedef struct {
      logic [4:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        ill;
   } vec_t;
   vec_t vt[19];

   function automatic logic [63:0] sext32(input logic [63:0] x);
      return {{32{x[31]}}, x[31:0]};
   endfunction

   function automatic logic [63:0] sra64(input logic [63:0] x, input int s);
      return x[63] ? ~((~x) >> s) : (x >> s);
   endfunction

   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      int s, sw;
      s  = int'(b[5:0]);
      sw = int'(b[4:0]);
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a & b;
         5'd3:  return a | b;
         5'd4:  return a ^ b;
         5'd5:  return a << s;
         5'd6:  return a >> s;
         5'd7:  return sra64(a, s);
         5'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         5'd9:  return (a < b) ? 64'd1 : 64'd0;
         5'd10: return a * 2 + b;
         5'd11: return a * 4 + b;
         5'd12: return a * 8 + b;
         5'd13: return sext32(a + b);
         5'd14: return sext32(a - b);
         5'd15: return sext32(a << sw);
         5'd16: return sext32({32'd0, a[31:0]} >> sw);
         5'd17: return sext32(sra64(sext32(a), sw));
         default: return 64'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [7:0] tag,
                        input logic ordy, input logic fl, input logic rs);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_rd     = rd;
      bus.in_tag    = tag;
      bus.out_ready = ordy;
      flush         = fl;
      rst           = rs;
   endtask

   task automatic cycle(input string name);
      logic acc;
      #1;
      check({name, " in_ready"}, 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 0; m_result = 0; m_rd = 0; m_tag = 0; m_ill = 0; m_ops = 0; m_stall = 0;
      end else begin
         acc = bus.in_valid && (!m_valid || bus.out_ready) && !flush;
         if (m_valid && !bus.out_ready && !flush) m_stall = m_stall + 1;
         if (acc) begin
            m_ops    = m_ops + 1;
            m_result = ref_alu(bus.in_op, bus.in_a, bus.in_b);
            m_rd     = bus.in_rd;
            m_tag    = bus.in_tag;
            m_ill    = (bus.in_op > 5'd17);
         end
         if (flush)                m_valid = 0;
         else if (acc)             m_valid = 1;
         else if (bus.out_ready)   m_valid = 0;
      end
      check({name, " out_valid"}, 64'(bus.out_valid), 64'(m_valid));
      check({name, " ops_count"}, 64'(ops_count), 64'(m_ops));
      check({name, " stall_count"}, 64'(stall_count), 64'(m_stall));
      if (m_valid) begin
         check({name, " out_result"}, bus.out_result, m_result);
         check({name, " out_rd"}, 64'(bus.out_rd), 64'(m_rd));
         check({name, " out_tag"}, 64'(bus.out_tag), 64'(m_tag));
         check({name, " out_illegal"}, 64'(bus.out_illegal), 64'(m_ill));
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
      check({name, " out_result"}, bus.out_result, 64'd0);
      check({name, " out_rd"}, 64'(bus.out_rd), 64'd0);
      check({name, " out_tag"}, 64'(bus.out_tag), 64'd0);
      check({name, " out_illegal"}, 64'(bus.out_illegal), 64'd0);
      check({name, " ops_count"}, 64'(ops_count), 64'd0);
      check({name, " stall_count"}, 64'(stall_count), 64'd0);
   endtask

   initial begin
      logic [CNT_W-1:0] ops0, stall0;
      logic [4:0]       rop;
      logic [63:0]      ra, rb;

      vt[0]  = '{5'd0,  64'd5, 64'd7, 64'd12, 1'b0};
      vt[1]  = '{5'd1,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vt[2]  = '{5'd2,  64'hF0F0, 64'hFF00, 64'hF000, 1'b0};
      vt[3]  = '{5'd3,  64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0};
      vt[4]  = '{5'd4,  64'hFF, 64'h0F, 64'hF0, 1'b0};
      vt[5]  = '{5'd5,  64'd1, 64'h41, 64'd2, 1'b0};
      vt[6]  = '{5'd6,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0};
      vt[7]  = '{5'd7,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0};
      vt[8]  = '{5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0};
      vt[9]  = '{5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
      vt[10] = '{5'd10, 64'd3, 64'd1, 64'd7, 1'b0};
      vt[11] = '{5'd11, 64'd3, 64'd1, 64'd13, 1'b0};
      vt[12] = '{5'd12, 64'd2, 64'd1, 64'd17, 1'b0};
      vt[13] = '{5'd13, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0};
      vt[14] = '{5'd14, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vt[15] = '{5'd15, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1'b0};
      vt[16] = '{5'd16, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 1'b0};
      vt[17] = '{5'd17, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b0};
      vt[18] = '{5'd20, 64'd3, 64'd4, 64'd0, 1'b1};

      m_valid = 0; m_result = 0; m_rd = 0; m_tag = 0; m_ill = 0; m_ops = 0; m_stall = 0;

      drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
      cycle("reset0");
      cycle("reset1");
      check_all_zero("after_reset");

      for (int i = 0; i < 19; i++) begin
         drive(1, vt[i].op, vt[i].a, vt[i].b, i[4:0], i[7:0], 1, 0, 0);
         cycle("vec");
         check($sformatf("vec%0d result", i), bus.out_result, vt[i].res);
         check($sformatf("vec%0d illegal", i), 64'(bus.out_illegal), 64'(vt[i].ill));
         check($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'd1);
         if (i == 0) check("first ops_count", 64'(ops_count), 64'd1);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      cycle("drain");
      check("drain valid", 64'(bus.out_valid), 64'd0);

      drive(1, 5'd0, 64'd100, 64'd23, 5'd9, 8'h5A, 0, 0, 0);
      cycle("hold_issue");
      stall0 = m_stall;
      for (int k = 0; k < 3; k++) begin
         drive(1, 5'd1, 64'd50, 64'd1, 5'd3, 8'h11, 0, 0, 0);
         cycle("stall");
         check("stall in_ready", 64'(bus.in_ready), 64'd0);
         check("stall result", bus.out_result, 64'd123);
         check("stall rd", 64'(bus.out_rd), 64'd9);
         check("stall tag", 64'(bus.out_tag), 64'h5A);
      end
      check("stall_count +3", 64'(stall_count), 64'(stall0 + 3));
      drive(1, 5'd1, 64'd10, 64'd3, 5'd4, 8'h22, 1, 0, 0);
      cycle("b2b");
      check("b2b valid", 64'(bus.out_valid), 64'd1);
      check("b2b result", bus.out_result, 64'd7);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("pre_flush");
      ops0 = m_ops;
      drive(1, 5'd0, 64'd1, 64'd1, 5'd1, 8'h33, 0, 1, 0);
      cycle("flush");
      check("flush valid", 64'(bus.out_valid), 64'd0);
      check("flush ops_count", 64'(ops_count), 64'(ops0));

      drive(1, 5'd4, 64'hAA, 64'h55, 5'd7, 8'h44, 1, 0, 0);
      cycle("pre_rst");
      drive(1, 5'd0, 64'd9, 64'd9, 5'd8, 8'h45, 0, 0, 1);
      cycle("mid_rst");
      check_all_zero("mid_rst");

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) rop = 5'(18 + $urandom_range(0, 13));
         else                           rop = 5'($urandom_range(0, 17));
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
         drive($urandom_range(0, 3) != 0, rop, ra, rb, 5'($urandom), 8'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 99) == 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage ALU with its EX/MEM output register; it consumes the decoded alu_op_t stream from the decode stage.
- Takes one operation per cycle over a valid/ready handshake, computes the 64-bit result and registers it, with rd/tag passthrough.
- Sits between the ID/EX boundary and the MEM stage of the 5-stage RV64I pipeline.
- Supports pipeline flush, backpressure, illegal-op flagging and two performance counters.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 8, width of the opaque instruction tag passed through.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill the held result and any op accepted this cycle.
- in_valid  in  1  upstream op present.
- in_ready  out  1  stage can accept an op this cycle.
- in_op  in  5  alu_op_t encoding, values 0..17.
- in_a  in  XLEN  operand A (rs1 or PC).
- in_b  in  XLEN  operand B (rs2 or immediate).
- in_rd  in  5  destination register index.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result held and valid.
- out_ready  in  1  downstream accepts the held result.
- out_result  out  XLEN  registered ALU result.
- out_rd  out  5  registered rd.
- out_tag  out  TAG_W  registered tag.
- out_illegal  out  1  held op encoding was 18..31.
- ops_count  out  CNT_W  count of accepted ops.
- stall_count  out  CNT_W  count of backpressure cycles.

Behaviour:
- Reset: out_valid=0, out_result=0, out_rd=0, out_tag=0, out_illegal=0, ops_count=0, stall_count=0. Reset overrides flush and all handshakes.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on flush.
- accept = in_valid && in_ready && !flush.
  - On accept: result, rd, tag and illegal are captured; out_valid goes to 1 next cycle. Latency is 1 cycle.
- Held result drains (out_valid && out_ready) with no accept that cycle: out_valid goes to 0.
- Drain and accept in the same cycle: the new op replaces the held one and out_valid stays 1. This gives full throughput of 1 op/cycle.
- out_valid && !out_ready: all out_* registers hold stable; nothing new is accepted.
- flush: out_valid goes to 0 next cycle and the incoming op is discarded. Data registers may keep stale values; only out_valid is meaningful.
- Arithmetic: a=in_a, b=in_b, all results are XLEN bits.
  - ADD a+b, SUB a-b, modulo 2^64.
  - AND, OR, XOR bitwise.
  - SLL a<<b[5:0], SRL logical >>b[5:0], SRA arithmetic >>b[5:0].
  - SLT: signed a<b gives 1, else 0. SLTU: same comparison, unsigned.
  - SH1ADD (a<<1)+b, SH2ADD (a<<2)+b, SH3ADD (a<<3)+b.
  - *W ops: operate on a[31:0]/b[31:0], shift amount b[4:0], and sign-extend bit 31 of the 32-bit result to 64.
  - SRLW zero-fills within 32 bits; SRAW shifts a[31:0] as signed; ADDW/SUBW wrap at 32 bits.
- Illegal op (in_op 18..31): result 0 and out_illegal=1. The op is still accepted and counted.
- ops_count increments by 1 per accept and wraps at 2^CNT_W.
- stall_count increments each cycle out_valid && !out_ready && !flush and wraps.

Test Plan:
- After reset, ADD a=5, b=7, out_ready=1 -> out_valid=1 one cycle later with out_result=12; ops_count=1.
- SRAW a=0x0000_0000_8000_0000, b=4 -> 0xFFFF_FFFF_F800_0000. ADDW a=0x7FFF_FFFF, b=1 -> 0xFFFF_FFFF_8000_0000.
- SLT a=-1, b=1 -> 1 and SLTU on the same operands -> 0. SH3ADD a=2, b=1 -> 17. SLL a=1, b=0x41 -> 2 (shift amount 1).
- Hold out_ready=0 for 3 cycles with a result held -> in_ready=0, outputs stable, stall_count=3. Raise out_ready with in_valid=1 -> back-to-back result, out_valid stays 1.
- Assert flush in the same cycle as in_valid=1 while a result is held -> out_valid=0 next cycle, ops_count unchanged.
- in_op=20, a=3, b=4 -> out_result=0, out_illegal=1. Assert rst mid-stream -> all outputs and counters 0 next cycle.
